serial_rx: RTL and testbench
============================

# serial_rx

Parametrised asynchronous serial receiver with a receive FIFO: the successor to the fixed 8N1 bench-only serial monitor. It oversamples a single idle-high RX line, assembles frames of configurable data width, parity and stop bits, and queues good characters for a host reader. It sits beside the `glacial` core, on the `uart_tx` net in simulation or on an external pin in FPGA builds, so traffic can be checked or looped back.

## Interface
- `CLK_DIV`, 16: clock cycles per bit; must be 4 or more.
- `DATA_BITS`, 8: data bits per character, 5 to 9.
- `PARITY`, 0: parity mode; 0 none, 1 odd, 2 even.
- `STOP_BITS`, 1: stop bits, 1 or 2.
- `DEPTH`, 16: FIFO entries; must be a power of two, 2 or more.

- `clk`  in  1  single clock.
- `reset`  in  1  asynchronous, active-high reset.
- `rx_data`  in  1  serial line, idle high, LSB first, asynchronous to `clk`.
- `rd_en`  in  1  pops the FIFO head; ignored while `empty`.
- `rd_data`  out  DATA_BITS  FIFO head (show-ahead); 0 while empty.
- `empty`  out  1  FIFO empty.
- `full`  out  1  FIFO full.
- `count`  out  $clog2(DEPTH)+1  number of entries in the FIFO.
- `busy`  out  1  receiver is inside a frame.
- `frame_err`  out  1  one-cycle pulse: a stop bit was sampled low.
- `parity_err`  out  1  one-cycle pulse: parity mismatch.
- `overrun`  out  1  one-cycle pulse: a good character was dropped because the FIFO was full.
- `break_det`  out  1  one-cycle pulse: all data bits 0 and the stop bit low.

## Operation
- `rx_data` passes through a 2-flop synchroniser; the FSM sees `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: moves to START on a falling edge of `rx_s` (previous sample 1, current 0).
  - START: waits floor(CLK_DIV/2) cycles, then samples `rx_s`. If 1, the start was a glitch; return to IDLE. If 0, go to DATA.
  - DATA: samples DATA_BITS bits, one every CLK_DIV cycles, shifting LSB first.
  - PARITY: present only when `PARITY` is not 0; samples one bit.
  - STOP: samples STOP_BITS bits. After the last stop sample the FSM returns to IDLE at mid-bit, so it can resync on the next start edge.
- Character disposition:
  - A stop bit sampled 0 pulses `frame_err`. If all data bits were also 0, `break_det` pulses too. The character is discarded.
  - A parity mismatch pulses `parity_err` and discards the character. Parity and frame errors can pulse in the same cycle.
  - A good character is written to the FIFO. If the FIFO is full and no pop happens that cycle, the character is dropped and `overrun` pulses.
- FIFO behaviour:
  - A simultaneous pop and push when full is accepted.
  - A simultaneous pop and push when empty leaves the FIFO holding the new character. `rd_en` is ignored because `empty` is 1.
  - Pointers wrap modulo DEPTH. `count` is the registered difference of the pointers.
- `busy` is 1 in every state except IDLE.

## Timing
- Reset values: `empty`=1, `full`=0, `count`=0, `rd_data`=0, `busy`=0, all error pulses 0. FSM in IDLE, synchroniser flops set to 1, FIFO pointers 0.
- Reset asserted mid-frame aborts the frame and clears the FIFO. After release, a line that is still low does not start a frame until a fresh 1-to-0 edge is seen.
- Let t0 be the first `clk` edge that registers `rx_data`=0.
  - Start check at t0 + 2 + floor(CLK_DIV/2).
  - Bit k (k = 0..) is sampled at start check + (k+1)·CLK_DIV.
- The FIFO write, `empty` deassertion and all error pulses occur one cycle after the last stop sample.
- `rd_en` high at edge n: `rd_data` shows the next entry after edge n, and `count` decrements at the same edge.

## Structure
- Package `serial_pkg` holds:
  - parity constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - the `rx_state_t` enum;
  - a `frame_bits()` function returning 1 + DATA_BITS + (PARITY != 0) + STOP_BITS.
- Sub-module `sync_fifo` (parameters WIDTH and DEPTH) provides push/pop/full/empty/count. The framer instantiates it once.

## Test plan
- Run all scenarios with CLK_DIV=16 unless stated.
- 8N1, send 0x55 with the edge at cycle 0 → `empty` falls at cycle 155, `rd_data`=0x55. One `rd_en` → `empty`=1, `count`=0.
- 8E1, send 0xA3 with a parity bit of 1 (should be 0) → `parity_err` pulses once, FIFO stays empty. Then send 0xA3 with a correct parity bit → `rd_data`=0xA3.
- Glitch: `rx_data` low for 5 cycles, then high → `busy` returns to 0 at start check, no error pulse, `count`=0.
- DEPTH=4, send 0x01..0x05 with no reads → `full`=1 after 0x04, `overrun` pulses on 0x05. Reads return 0x01..0x04 in order.
- Hold `rx_data` low for 12 bit times → exactly one `frame_err` and one `break_det` pulse, no FIFO write, no new frame until the line returns high.
- 7O2, CLK_DIV=5: send 0x7F, assert `reset` mid-data, release, then send 0x12 → FIFO holds only 0x12, `count`=1.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial receiver: parity modes, receiver FSM states
// and the total frame length helper.
package serial_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; head visible combinationally, reads 0 while empty.
// Push while full is refused unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       wdata_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rd_q];
    assign count_o = count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata_i;
    end

endmodule

// File: rtl/serial_rx.sv
// Oversampling async serial receiver feeding a show-ahead FIFO; characters and error
// pulses appear one cycle after the last stop sample; a full FIFO drops characters (overrun).
module serial_rx
    import serial_pkg::*;
#(
    parameter int CLK_DIV   = 16,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1,
    parameter int DEPTH     = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx_data,
    input  logic                   rd_en,
    output logic [DATA_BITS-1:0]   rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   busy,
    output logic                   frame_err,
    output logic                   parity_err,
    output logic                   overrun,
    output logic                   break_det
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int BW = $clog2(frame_bits(DATA_BITS, PARITY, STOP_BITS));
    localparam logic [CW-1:0] HALF_LD   = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_LD    = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          PAR_EN    = (PARITY != PAR_NONE);
    localparam logic          PAR_TGT   = (PARITY == PAR_ODD);

    logic                 s1_q, rx_s_q, rx_prev_q;
    logic [1:0]           vld_q;
    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d, ferr_q, ferr_d, done_q, done_d;
    logic                 frame_err_q, parity_err_q, overrun_q, break_q;
    logic                 rx_fall, tick, par_bad, good, pop;

    assign rx_fall = rx_prev_q & ~rx_s_q;
    assign tick    = (cnt_q == '0);
    assign par_bad = PAR_EN & ((^shift_q ^ par_q) != PAR_TGT);
    assign good    = done_q & ~ferr_q & ~par_bad;
    assign pop     = rd_en & ~empty;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        if (state_q != ST_IDLE && !tick) cnt_d = cnt_q - 1'b1;
        case (state_q)
            ST_IDLE: if (rx_fall) begin
                state_d = ST_START;
                cnt_d   = HALF_LD;
            end
            ST_START: if (tick) begin
                state_d = rx_s_q ? ST_IDLE : ST_DATA;
                cnt_d   = BIT_LD;
                bit_d   = '0;
                ferr_d  = 1'b0;
            end
            ST_DATA: if (tick) begin
                shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                cnt_d   = BIT_LD;
                if (bit_q == DATA_LAST) begin
                    bit_d   = '0;
                    state_d = PAR_EN ? ST_PARITY : ST_STOP;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            ST_PARITY: if (tick) begin
                par_d   = rx_s_q;
                cnt_d   = BIT_LD;
                state_d = ST_STOP;
            end
            ST_STOP: if (tick) begin
                ferr_d = ferr_q | ~rx_s_q;
                cnt_d  = BIT_LD;
                // Leave at mid-bit of the last stop so the next start edge is caught.
                if (bit_q == STOP_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    bit_d = bit_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q         <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_prev_q    <= 1'b0;
            vld_q        <= '0;
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            ferr_q       <= 1'b0;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
            break_q      <= 1'b0;
        end else begin
            s1_q      <= rx_data;
            rx_s_q    <= s1_q;
            vld_q     <= {vld_q[0], 1'b1};
            // Edge history only counts once the synchroniser holds real line samples,
            // so a line still low after reset cannot fake a start edge.
            rx_prev_q <= rx_s_q & vld_q[1];
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            ferr_q    <= ferr_d;
            done_q    <= done_d;
            frame_err_q  <= done_q & ferr_q;
            break_q      <= done_q & ferr_q & ~|shift_q;
            parity_err_q <= done_q & par_bad;
            overrun_q    <= good & full & ~pop;
        end
    end

    assign busy       = (state_q != ST_IDLE);
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;
    assign break_det  = break_q;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (good),
        .wdata_i (shift_q),
        .pop_i   (rd_en),
        .rdata_o (rd_data),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

endmodule

// File: tb/tb_serial_rx.sv
// Directed plus randomized bench for serial_rx: four configurations share one clock,
// each line driven from a bit-level frame builder and checked against a queue model.
module tb_serial_rx;
    import serial_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rx_w, rden;
    logic [3:0] empty_w, full_w, busy_w, fe_w, pe_w, ov_w, bk_w;
    logic [7:0] rd0, rd1, rd2;
    logic [6:0] rd3;
    logic [4:0] cnt0, cnt1, cnt3;
    logic [2:0] cnt2;

    int total = 0, bad = 0, cyc = 0, t0 = 0, fall_cyc = -1;
    int fe_cnt[4] = '{0, 0, 0, 0};
    int pe_cnt[4] = '{0, 0, 0, 0};
    int ov_cnt[4] = '{0, 0, 0, 0};
    int bk_cnt[4] = '{0, 0, 0, 0};
    logic prev_e0 = 1'b1;
    int exp_fe = 0, exp_bk = 0, exp_pe = 0;
    int q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_rx #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .DEPTH(16)) u0 (
        .clk(clk), .reset(reset), .rx_data(rx_w[0]), .rd_en(rden[0]), .rd_data(rd0),
        .empty(empty_w[0]), .full(full_w[0]), .count(cnt0), .busy(busy_w[0]),
        .frame_err(fe_w[0]), .parity_err(pe_w[0]), .overrun(ov_w[0]), .break_det(bk_w[0]));
    serial_rx #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1), .DEPTH(16)) u1 (
        .clk(clk), .reset(reset), .rx_data(rx_w[1]), .rd_en(rden[1]), .rd_data(rd1),
        .empty(empty_w[1]), .full(full_w[1]), .count(cnt1), .busy(busy_w[1]),
        .frame_err(fe_w[1]), .parity_err(pe_w[1]), .overrun(ov_w[1]), .break_det(bk_w[1]));
    serial_rx #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(1), .DEPTH(4)) u2 (
        .clk(clk), .reset(reset), .rx_data(rx_w[2]), .rd_en(rden[2]), .rd_data(rd2),
        .empty(empty_w[2]), .full(full_w[2]), .count(cnt2), .busy(busy_w[2]),
        .frame_err(fe_w[2]), .parity_err(pe_w[2]), .overrun(ov_w[2]), .break_det(bk_w[2]));
    serial_rx #(.CLK_DIV(5), .DATA_BITS(7), .PARITY(PAR_ODD), .STOP_BITS(2), .DEPTH(16)) u3 (
        .clk(clk), .reset(reset), .rx_data(rx_w[3]), .rd_en(rden[3]), .rd_data(rd3),
        .empty(empty_w[3]), .full(full_w[3]), .count(cnt3), .busy(busy_w[3]),
        .frame_err(fe_w[3]), .parity_err(pe_w[3]), .overrun(ov_w[3]), .break_det(bk_w[3]));

    // Pulse counters and the cycle at which instance 0 first goes non-empty.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            fe_cnt[i] += int'(fe_w[i]);
            pe_cnt[i] += int'(pe_w[i]);
            ov_cnt[i] += int'(ov_w[i]);
            bk_cnt[i] += int'(bk_w[i]);
        end
        if (fall_cyc < 0 && prev_e0 && !empty_w[0]) fall_cyc = cyc;
        prev_e0 = empty_w[0];
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] mkframe(input int d, input int nd, input int pm,
                                            input bit flip, input bit stop_ok, input int ns);
        logic [15:0] f;
        int pos, ones;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < nd; i++) f[1 + i] = d[i];
        pos  = nd + 1;
        ones = $countones(d & ((1 << nd) - 1));
        if (pm != PAR_NONE) begin
            f[pos] = ((pm == PAR_EVEN) ? (ones % 2 == 1) : (ones % 2 == 0)) ^ flip;
            pos++;
        end
        for (int s = 0; s < ns; s++) f[pos + s] = stop_ok;
        return f;
    endfunction

    task automatic send(input int inst, input logic [15:0] f, input int nb, input int div);
        for (int i = 0; i < nb; i++) begin
            rx_w[inst] = f[i];
            repeat (div) @(negedge clk);
        end
        rx_w[inst] = 1'b1;
        repeat (div) @(negedge clk);
    endtask

    task automatic pop_check(input int inst, input int exp, input string tag);
        int d;
        case (inst)
            0:       d = int'(rd0);
            1:       d = int'(rd1);
            2:       d = int'(rd2);
            default: d = int'(rd3);
        endcase
        check(tag, d, exp);
        rden[inst] = 1'b1;
        @(negedge clk);
        rden[inst] = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        rx_w  = '1;
        rden  = '0;
        idle(3);
        check("rst_empty", int'(empty_w), 15);
        check("rst_full", int'(full_w), 0);
        check("rst_busy", int'(busy_w), 0);
        check("rst_cnt", int'(cnt0), 0);
        check("rst_rd", int'(rd0), 0);
        check("rst_pulses", int'(fe_w | pe_w | ov_w | bk_w), 0);
        reset = 1'b0;
        idle(4);

        // 8N1 latency: edge to non-empty is 2 + CLK_DIV/2 + 9*CLK_DIV + 1.
        t0 = cyc + 1;
        send(0, mkframe('h55, 8, PAR_NONE, 1'b0, 1'b1, 1), frame_bits(8, PAR_NONE, 1), 16);
        check("n1_latency", fall_cyc - t0, 155);
        check("n1_data", int'(rd0), 'h55);
        check("n1_cnt", int'(cnt0), 1);
        pop_check(0, 'h55, "n1_pop");
        check("n1_empty", int'(empty_w[0]), 1);
        check("n1_cnt0", int'(cnt0), 0);

        // Glitch shorter than half a bit.
        t0 = cyc + 1;
        rx_w[0] = 1'b0;
        idle(5);
        rx_w[0] = 1'b1;
        while (cyc < t0 + 9) @(negedge clk);
        check("gl_busy_before", int'(busy_w[0]), 1);
        idle(1);
        check("gl_busy_after", int'(busy_w[0]), 0);
        idle(20);
        check("gl_errs", fe_cnt[0] + pe_cnt[0] + bk_cnt[0], 0);
        check("gl_cnt", int'(cnt0), 0);

        // 8E1 bad then good parity.
        send(1, mkframe('hA3, 8, PAR_EVEN, 1'b1, 1'b1, 1), frame_bits(8, PAR_EVEN, 1), 16);
        check("e1_perr", pe_cnt[1], 1);
        check("e1_empty", int'(empty_w[1]), 1);
        send(1, mkframe('hA3, 8, PAR_EVEN, 1'b0, 1'b1, 1), frame_bits(8, PAR_EVEN, 1), 16);
        check("e1_perr_once", pe_cnt[1], 1);
        pop_check(1, 'hA3, "e1_data");
        exp_pe = 1;

        // Random 8E1 traffic with occasional parity corruption.
        for (int n = 0; n < 8; n++) begin
            int d;
            bit flip;
            d    = int'($urandom_range(0, 255));
            flip = ($urandom_range(0, 3) == 0);
            send(1, mkframe(d, 8, PAR_EVEN, flip, 1'b1, 1), frame_bits(8, PAR_EVEN, 1), 16);
            if (flip) exp_pe++;
            else      q.push_back(d);
        end
        check("re_cnt", int'(cnt1), q.size());
        check("re_perr", pe_cnt[1], exp_pe);
        check("re_ferr", fe_cnt[1], 0);
        while (q.size() > 0) pop_check(1, q.pop_front(), "re_data");
        check("re_empty", int'(empty_w[1]), 1);

        // Random 8N1 traffic with occasional bad stop bits, including zero data.
        for (int n = 0; n < 8; n++) begin
            int d;
            bit ok;
            d  = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 255));
            ok = ($urandom_range(0, 3) != 0);
            send(0, mkframe(d, 8, PAR_NONE, 1'b0, ok, 1), frame_bits(8, PAR_NONE, 1), 16);
            if (ok) q.push_back(d);
            else begin
                exp_fe++;
                if (d == 0) exp_bk++;
            end
        end
        check("rn_cnt", int'(cnt0), q.size());
        check("rn_ferr", fe_cnt[0], exp_fe);
        check("rn_brk", bk_cnt[0], exp_bk);
        while (q.size() > 0) pop_check(0, q.pop_front(), "rn_data");

        // Line held low for 12 bit times.
        rx_w[0] = 1'b0;
        idle(12 * 16);
        check("bk_busy_low", int'(busy_w[0]), 0);
        check("bk_ferr", fe_cnt[0], exp_fe + 1);
        check("bk_brk", bk_cnt[0], exp_bk + 1);
        rx_w[0] = 1'b1;
        idle(40);
        check("bk_busy_high", int'(busy_w[0]), 0);
        check("bk_ferr_once", fe_cnt[0], exp_fe + 1);
        check("bk_cnt", int'(cnt0), 0);

        // DEPTH=4: fill, overrun, drain.
        for (int v = 1; v <= 5; v++) begin
            send(2, mkframe(v, 8, PAR_NONE, 1'b0, 1'b1, 1), frame_bits(8, PAR_NONE, 1), 16);
            if (v == 3) check("d4_notfull", int'(full_w[2]), 0);
            if (v == 4) check("d4_full", int'(full_w[2]), 1);
        end
        check("d4_overrun", ov_cnt[2], 1);
        check("d4_cnt", int'(cnt2), 4);
        for (int v = 1; v <= 4; v++) pop_check(2, v, "d4_data");
        check("d4_empty", int'(empty_w[2]), 1);
        check("d4_rd_zero", int'(rd2), 0);

        // 7O2 at CLK_DIV=5: reset mid-frame flushes the FIFO; low line after release is inert.
        send(3, mkframe('h33, 7, PAR_ODD, 1'b0, 1'b1, 2), frame_bits(7, PAR_ODD, 2), 5);
        check("o2_pre_cnt", int'(cnt3), 1);
        rx_w[3] = 1'b0;
        idle(5);
        rx_w[3] = 1'b1;
        idle(10);
        rx_w[3] = 1'b0;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(30);
        check("o2_rst_busy", int'(busy_w[3]), 0);
        check("o2_rst_empty", int'(empty_w[3]), 1);
        check("o2_rst_cnt", int'(cnt3), 0);
        check("o2_rst_ferr", fe_cnt[3], 0);
        rx_w[3] = 1'b1;
        idle(10);
        send(3, mkframe('h12, 7, PAR_ODD, 1'b0, 1'b1, 2), frame_bits(7, PAR_ODD, 2), 5);
        check("o2_cnt", int'(cnt3), 1);
        check("o2_errs", fe_cnt[3] + pe_cnt[3], 0);
        pop_check(3, 'h12, "o2_data");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
